// File: rtl/sbox_array.sv
// sbox_array: multi-lane AES SubBytes / InvSubBytes unit with a valid/ready
// pipeline of PIPE_STAGES registers. The substitution is computed
// combinationally ahead of stage 0; later stages only retime. All lanes share
// the per-beat in_inv mode bit.
module sbox_array #(
    parameter int NUM_LANES   = 4,
    parameter int PIPE_STAGES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [8*NUM_LANES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_inv,
    output logic [8*NUM_LANES-1:0] out_data
);

    localparam int W = 8 * NUM_LANES;

    // Reject configurations outside the supported range at elaboration.
    if (NUM_LANES < 1 || NUM_LANES > 16) begin : g_bad_lanes
        $error("sbox_array: NUM_LANES must be in 1..16");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
        $error("sbox_array: PIPE_STAGES must be in 1..3");
    end

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) r = gf_mul(r, p);
            else       r = r;
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Forward S-box: field inverse followed by the affine transform.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] q;
        q = gf_inv(b);
        return q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

    logic [W-1:0]           sub_s;
    logic [PIPE_STAGES-1:0] adv_s;
    logic [PIPE_STAGES-1:0] valid_r;
    logic [PIPE_STAGES-1:0] inv_r;
    logic [W-1:0]           data_r [PIPE_STAGES];

    // Per-lane byte substitution of the incoming beat.
    always_comb begin
        sub_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sub_s[8*i +: 8] = in_inv ? inv_sbox(in_data[8*i +: 8]) : fwd_sbox(in_data[8*i +: 8]);
        end
    end

    // Advance chain: a stage moves when it is empty or everything after it moves.
    always_comb begin
        logic chain;
        adv_s = '0;
        chain = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            chain    = !valid_r[k] || chain;
            adv_s[k] = chain;
        end
    end

    // Pipeline registers: stage 0 captures the lookup, later stages retime.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            inv_r   <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            if (adv_s[0]) begin
                valid_r[0] <= in_valid;
                inv_r[0]   <= in_inv;
                data_r[0]  <= sub_s;
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (adv_s[k]) begin
                    valid_r[k] <= valid_r[k-1];
                    inv_r[k]   <= inv_r[k-1];
                    data_r[k]  <= data_r[k-1];
                end
            end
        end
    end

    assign in_ready  = adv_s[0];
    assign out_valid = valid_r[PIPE_STAGES-1];
    assign out_inv   = inv_r[PIPE_STAGES-1];
    assign out_data  = data_r[PIPE_STAGES-1];

endmodule
